// File: rtl/ppu_bg_fetcher.sv
// Background tile fetcher: walks one scanline of the BG tile map and decodes the tile rows.
// Decoded pixels go into a 16-entry FIFO that the pixel mixer drains one pixel per dot.
module ppu_bg_fetcher (
  input  logic        clk,
  input  logic        reset,
  input  logic        dot_en,
  input  logic        cgb,
  input  logic        start,
  input  logic        stop,
  input  logic        bg_map_sel,
  input  logic        tile_data_sel,
  input  logic [7:0]  scx,
  input  logic [7:0]  scy,
  input  logic [7:0]  ly,
  output logic [12:0] vram_addr,
  input  logic [7:0]  vram_rdata_bank0,
  input  logic [7:0]  vram_rdata_bank1,
  output logic        pix_valid,
  output logic [1:0]  pix_color,
  output logic [2:0]  pix_pal,
  output logic        pix_prio,
  input  logic        pix_pop,
  output logic [4:0]  fifo_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T_ADDR = 3'd1,
    S_T_DATA = 3'd2,
    S_L_ADDR = 3'd3,
    S_L_DATA = 3'd4,
    S_H_ADDR = 3'd5,
    S_H_DATA = 3'd6,
    S_PUSH   = 3'd7
  } state_t;

  state_t state, state_next;

  // Line context latched on start
  logic [7:0]  y_q;
  logic [4:0]  x_tile_q;
  logic [2:0]  discard_q;

  // Current tile context
  logic [7:0]  tile_q;
  logic        prio_q, yflip_q, xflip_q, bank_q;
  logic [2:0]  pal_q;
  logic [7:0]  lo_q, hi_q;

  // Pixel FIFO: entry = {prio, pal[2:0], colour[1:0]}
  logic [5:0]  fifo_mem [16];
  logic [3:0]  rd_ptr, wr_ptr;
  logic [4:0]  count_q;

  // Control strobes from the FSM
  logic        flush, latch_line, cap_tile, cap_lo, cap_hi, do_push, addr_load;
  logic [12:0] addr_next;

  logic [7:0]  y_start;
  logic [7:0]  row_data;
  logic        pop_ok, drop, take;
  logic [5:0]  head;

  assign y_start  = ly + scy;
  assign row_data = bank_q ? vram_rdata_bank1 : vram_rdata_bank0;

  function automatic logic [12:0] tile_row_addr(input logic [7:0] tile, input logic yflip,
                                                input logic [7:0] y, input logic sel,
                                                input logic hi);
    logic [2:0] row;
    row = yflip ? ~y[2:0] : y[2:0];
    return {sel ? 1'b0 : ~tile[7], tile, row, hi};
  endfunction

  // Slot 0 is the leftmost pixel; without xflip that is bit 7 (~slot == 7 - slot).
  function automatic logic [5:0] pix_entry(input logic prio, input logic [2:0] pal,
                                           input logic xflip, input logic [7:0] lo,
                                           input logic [7:0] hi, input logic [2:0] slot);
    logic [2:0] b;
    b = xflip ? slot : ~slot;
    return {prio, pal, hi[b], lo[b]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else if (dot_en) begin
      state <= state_next;
    end
  end

  // Addresses are registered: each *_ADDR state shows the address loaded on entry.
  always_comb begin
    state_next = state;
    flush      = 1'b0;
    latch_line = 1'b0;
    cap_tile   = 1'b0;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    do_push    = 1'b0;
    addr_load  = 1'b0;
    addr_next  = vram_addr;
    if (stop) begin
      state_next = S_IDLE;
      flush      = 1'b1;
    end else if (start) begin
      state_next = S_T_ADDR;
      flush      = 1'b1;
      latch_line = 1'b1;
      addr_load  = 1'b1;
      addr_next  = {2'b11, bg_map_sel, y_start[7:3], scx[7:3]};
    end else begin
      case (state)
        S_IDLE: state_next = S_IDLE;
        S_T_ADDR: state_next = S_T_DATA;
        S_T_DATA: begin
          state_next = S_L_ADDR;
          cap_tile   = 1'b1;
          addr_load  = 1'b1;
          addr_next  = tile_row_addr(vram_rdata_bank0, cgb & vram_rdata_bank1[6], y_q,
                                     tile_data_sel, 1'b0);
        end
        S_L_ADDR: state_next = S_L_DATA;
        S_L_DATA: begin
          state_next = S_H_ADDR;
          cap_lo     = 1'b1;
          addr_load  = 1'b1;
          addr_next  = tile_row_addr(tile_q, yflip_q, y_q, tile_data_sel, 1'b1);
        end
        S_H_ADDR: state_next = S_H_DATA;
        S_H_DATA: begin
          state_next = S_PUSH;
          cap_hi     = 1'b1;
        end
        S_PUSH: begin
          if (count_q <= 5'd8) begin
            state_next = S_T_ADDR;
            do_push    = 1'b1;
            addr_load  = 1'b1;
            addr_next  = {2'b11, bg_map_sel, y_q[7:3], x_tile_q + 5'd1};
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Discard and pop are exclusive: pix_valid is low while discard is non-zero.
  assign pix_valid = (count_q != 5'd0) && (discard_q == 3'd0);
  assign pop_ok    = pix_pop && pix_valid;
  assign drop      = (discard_q != 3'd0) && (count_q != 5'd0);
  assign take      = pop_ok || drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vram_addr <= 13'h0000;
      y_q       <= 8'h00;
      x_tile_q  <= 5'd0;
      discard_q <= 3'd0;
      tile_q    <= 8'h00;
      prio_q    <= 1'b0;
      yflip_q   <= 1'b0;
      xflip_q   <= 1'b0;
      bank_q    <= 1'b0;
      pal_q     <= 3'd0;
      lo_q      <= 8'h00;
      hi_q      <= 8'h00;
    end else if (dot_en) begin
      if (addr_load) begin
        vram_addr <= addr_next;
      end
      if (latch_line) begin
        y_q       <= y_start;
        x_tile_q  <= scx[7:3];
        discard_q <= scx[2:0];
      end else if (flush) begin
        discard_q <= 3'd0;
      end else begin
        if (drop) begin
          discard_q <= discard_q - 3'd1;
        end
        if (do_push) begin
          x_tile_q <= x_tile_q + 5'd1;
        end
      end
      if (cap_tile) begin
        tile_q  <= vram_rdata_bank0;
        prio_q  <= cgb & vram_rdata_bank1[7];
        yflip_q <= cgb & vram_rdata_bank1[6];
        xflip_q <= cgb & vram_rdata_bank1[5];
        bank_q  <= cgb & vram_rdata_bank1[3];
        pal_q   <= cgb ? vram_rdata_bank1[2:0] : 3'd0;
      end
      if (cap_lo) begin
        lo_q <= row_data;
      end
      if (cap_hi) begin
        hi_q <= row_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= 4'd0;
      wr_ptr  <= 4'd0;
      count_q <= 5'd0;
      for (int i = 0; i < 16; i++) begin
        fifo_mem[i] <= 6'd0;
      end
    end else if (dot_en) begin
      if (flush) begin
        rd_ptr  <= 4'd0;
        wr_ptr  <= 4'd0;
        count_q <= 5'd0;
      end else begin
        if (do_push) begin
          for (int i = 0; i < 8; i++) begin
            fifo_mem[wr_ptr + 4'(i)] <= pix_entry(prio_q, pal_q, xflip_q, lo_q, hi_q, 3'(i));
          end
          wr_ptr <= wr_ptr + 4'd8;
        end
        if (take) begin
          rd_ptr <= rd_ptr + 4'd1;
        end
        count_q <= count_q + (do_push ? 5'd8 : 5'd0) - {4'd0, take};
      end
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign pix_prio   = pix_valid & head[5];
  assign pix_pal    = pix_valid ? head[4:2] : 3'd0;
  assign pix_color  = pix_valid ? head[1:0] : 2'd0;
  assign fifo_count = count_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// Directed bench for ppu_bg_fetcher: a VRAM model feeds the fetcher, and scoreboard
// monitors compare issued VRAM addresses and popped pixels against expected queues.
module tb_ppu_bg_fetcher;

  logic        clk = 1'b0;
  logic        reset, dot_en, cgb, start, stop, bg_map_sel, tile_data_sel;
  logic [7:0]  scx, scy, ly;
  logic [12:0] vram_addr;
  logic [7:0]  vram_rdata_bank0 = 8'h00;
  logic [7:0]  vram_rdata_bank1 = 8'h00;
  logic        pix_valid, pix_prio, pix_pop;
  logic [1:0]  pix_color;
  logic [2:0]  pix_pal;
  logic [4:0]  fifo_count;
  logic [2:0]  state_dbg;

  logic [7:0]  bank0 [8192];
  logic [7:0]  bank1 [8192];

  logic [12:0] exp_addr_q [$];
  logic [5:0]  exp_pix_q [$];

  int checks = 0;
  int failures = 0;

  ppu_bg_fetcher dut (
    .clk              (clk),
    .reset            (reset),
    .dot_en           (dot_en),
    .cgb              (cgb),
    .start            (start),
    .stop             (stop),
    .bg_map_sel       (bg_map_sel),
    .tile_data_sel    (tile_data_sel),
    .scx              (scx),
    .scy              (scy),
    .ly               (ly),
    .vram_addr        (vram_addr),
    .vram_rdata_bank0 (vram_rdata_bank0),
    .vram_rdata_bank1 (vram_rdata_bank1),
    .pix_valid        (pix_valid),
    .pix_color        (pix_color),
    .pix_pal          (pix_pal),
    .pix_prio         (pix_prio),
    .pix_pop          (pix_pop),
    .fifo_count       (fifo_count),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / VRAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dot_en) begin
      vram_rdata_bank0 <= bank0[vram_addr];
      vram_rdata_bank1 <= bank1[vram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address monitor: one compare per *_ADDR state while expectations are queued.
  always @(negedge clk) begin
    logic [12:0] e;
    if (!reset && dot_en && (state_dbg == 3'd1 || state_dbg == 3'd3 || state_dbg == 3'd5)
        && exp_addr_q.size() != 0) begin
      e = exp_addr_q.pop_front();
      check("vram_addr", {19'd0, vram_addr}, {19'd0, e});
    end
  end

  // Pixel monitor: every accepted pop is compared with the head of the expected queue.
  always @(negedge clk) begin
    logic [5:0] e;
    if (!reset && dot_en && pix_pop && pix_valid) begin
      if (exp_pix_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pixel_unexpected actual=0x%0h required=none at %0t",
                 {pix_prio, pix_pal, pix_color}, $time);
      end else begin
        e = exp_pix_q.pop_front();
        check("pixel", {26'd0, pix_prio, pix_pal, pix_color}, {26'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // colors: eight 2-bit colours, leftmost pixel in bits [15:14]
  task automatic expect_tile(input logic prio, input logic [2:0] pal, input logic [15:0] colors,
                             input int skip);
    for (int i = skip; i < 8; i++) begin
      exp_pix_q.push_back({prio, pal, colors[15 - 2*i -: 2]});
    end
  endtask

  task automatic start_line(input logic [7:0] sx, input logic [7:0] sy, input logic [7:0] l);
    scx = sx;
    scy = sy;
    ly = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_line(input string name);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check({name, "_stop_count"}, {27'd0, fifo_count}, 32'd0);
    check({name, "_stop_valid"}, {31'd0, pix_valid}, 32'd0);
    check({name, "_stop_state"}, {29'd0, state_dbg}, 32'd0);
  endtask

  task automatic pop_pixels(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      while (!pix_valid && w < 50) begin
        tick();
        w++;
      end
      if (w == 50) check("pop_wait", {31'd0, pix_valid}, 32'd1);
      pix_pop = 1'b1;
      tick();
      pix_pop = 1'b0;
    end
  endtask

  task automatic drain_check(input string name);
    check({name, "_addr_left"}, exp_addr_q.size(), 32'd0);
    check({name, "_pix_left"}, exp_pix_q.size(), 32'd0);
    exp_addr_q.delete();
    exp_pix_q.delete();
  endtask

  task automatic run_basic(input string name);
    cgb = 1'b0;
    bg_map_sel = 1'b0;
    tile_data_sel = 1'b1;
    exp_addr_q.push_back(13'h1800);
    exp_addr_q.push_back(13'h0050);
    exp_addr_q.push_back(13'h0051);
    expect_tile(1'b0, 3'd0, 16'hF5A0, 0);
    start_line(8'h00, 8'h00, 8'h00);
    repeat (6) tick();
    check({name, "_count_n7"}, {27'd0, fifo_count}, 32'd0);
    tick();
    check({name, "_count_n8"}, {27'd0, fifo_count}, 32'd8);
    check({name, "_valid_n8"}, {31'd0, pix_valid}, 32'd1);
    pop_pixels(8);
    stop_line(name);
    drain_check(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    dot_en = 1'b1;
    cgb = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    bg_map_sel = 1'b0;
    tile_data_sel = 1'b1;
    scx = 8'h00;
    scy = 8'h00;
    ly = 8'h00;
    pix_pop = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      bank0[i] = 8'h00;
      bank1[i] = 8'h00;
    end
    bank0[13'h1800] = 8'h05;
    bank1[13'h1800] = 8'hEF;   // must be ignored while cgb = 0
    bank0[13'h0050] = 8'hF0;
    bank0[13'h0051] = 8'hCC;

    repeat (3) tick();
    check("rst_vram_addr", {19'd0, vram_addr}, 32'd0);
    check("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check("rst_pix_color", {30'd0, pix_color}, 32'd0);
    check("rst_pix_pal", {29'd0, pix_pal}, 32'd0);
    check("rst_pix_prio", {31'd0, pix_prio}, 32'd0);
    check("rst_fifo_count", {27'd0, fifo_count}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    reset = 1'b0;
    tick();

    run_basic("basic");

    // Signed tile addressing: tile 0x80 then tile 0x00, y = 3
    bank0[13'h1800] = 8'h80;
    bank0[13'h0806] = 8'hAA;
    bank0[13'h0807] = 8'h0F;
    bank0[13'h1006] = 8'h00;
    bank0[13'h1007] = 8'hFF;
    tile_data_sel = 1'b0;
    exp_addr_q.push_back(13'h1800);
    exp_addr_q.push_back(13'h0806);
    exp_addr_q.push_back(13'h0807);
    exp_addr_q.push_back(13'h1801);
    exp_addr_q.push_back(13'h1006);
    exp_addr_q.push_back(13'h1007);
    expect_tile(1'b0, 3'd0, 16'h44EE, 0);
    expect_tile(1'b0, 3'd0, 16'hAAAA, 0);
    start_line(8'h00, 8'h00, 8'h03);
    repeat (7) tick();
    check("signed_count_n8", {27'd0, fifo_count}, 32'd8);
    pop_pixels(16);
    stop_line("signed");
    drain_check("signed");
    bank0[13'h1800] = 8'h05;
    tile_data_sel = 1'b1;

    // CGB attributes: prio, yflip, xflip, bank 1, palette 3 on map 0x1C00, y = 1
    bank0[13'h1C00] = 8'h12;
    bank1[13'h1C00] = 8'hEB;
    bank1[13'h012C] = 8'hF0;
    bank1[13'h012D] = 8'hCC;
    bank0[13'h012C] = 8'h0F;
    bank0[13'h012D] = 8'h33;
    cgb = 1'b1;
    bg_map_sel = 1'b1;
    exp_addr_q.push_back(13'h1C00);
    exp_addr_q.push_back(13'h012C);
    exp_addr_q.push_back(13'h012D);
    expect_tile(1'b1, 3'd3, 16'h0A5F, 0);
    start_line(8'h00, 8'h00, 8'h01);
    pop_pixels(8);
    stop_line("cgb");
    drain_check("cgb");
    cgb = 1'b0;
    bg_map_sel = 1'b0;

    // Fine scroll and map wrap: scx = 0xFD -> column 31 then column 0, discard 5
    bank0[13'h181F] = 8'h07;
    bank0[13'h0070] = 8'h35;
    bank0[13'h0071] = 8'h0F;
    exp_addr_q.push_back(13'h181F);
    exp_addr_q.push_back(13'h0070);
    exp_addr_q.push_back(13'h0071);
    exp_addr_q.push_back(13'h1800);
    exp_addr_q.push_back(13'h0050);
    exp_addr_q.push_back(13'h0051);
    expect_tile(1'b0, 3'd0, 16'h05BB, 5);
    expect_tile(1'b0, 3'd0, 16'hF5A0, 0);
    start_line(8'hFD, 8'h00, 8'h00);
    pix_pop = 1'b1;   // pops while nothing is valid must be ignored
    repeat (6) tick();
    check("scroll_count_n7", {27'd0, fifo_count}, 32'd0);
    tick();
    check("scroll_count_n8", {27'd0, fifo_count}, 32'd8);
    check("scroll_valid_n8", {31'd0, pix_valid}, 32'd0);
    repeat (4) tick();
    check("scroll_count_n12", {27'd0, fifo_count}, 32'd4);
    check("scroll_valid_n12", {31'd0, pix_valid}, 32'd0);
    pix_pop = 1'b0;
    tick();
    check("scroll_valid_n13", {31'd0, pix_valid}, 32'd1);
    check("scroll_count_n13", {27'd0, fifo_count}, 32'd3);
    pop_pixels(11);
    stop_line("scroll");
    drain_check("scroll");

    // Backpressure: no pops until the FIFO is full and the fetcher holds in PUSH
    exp_addr_q.push_back(13'h1800);
    exp_addr_q.push_back(13'h0050);
    exp_addr_q.push_back(13'h0051);
    expect_tile(1'b0, 3'd0, 16'hF5A0, 7);
    exp_pix_q.delete();
    exp_pix_q.push_back(6'd3);
    start_line(8'h00, 8'h00, 8'h00);
    repeat (7) tick();
    check("bp_count_n8", {27'd0, fifo_count}, 32'd8);
    repeat (7) tick();
    check("bp_count_n15", {27'd0, fifo_count}, 32'd16);
    repeat (7) tick();
    check("bp_state_n22", {29'd0, state_dbg}, 32'd7);
    check("bp_count_n22", {27'd0, fifo_count}, 32'd16);
    repeat (5) tick();
    check("bp_count_hold", {27'd0, fifo_count}, 32'd16);
    check("bp_state_hold", {29'd0, state_dbg}, 32'd7);
    check("bp_addr_hold", {19'd0, vram_addr}, 32'h0001);
    dot_en = 1'b0;
    pix_pop = 1'b1;
    repeat (3) tick();
    check("freeze_count", {27'd0, fifo_count}, 32'd16);
    check("freeze_addr", {19'd0, vram_addr}, 32'h0001);
    check("freeze_state", {29'd0, state_dbg}, 32'd7);
    dot_en = 1'b1;
    tick();
    pix_pop = 1'b0;
    check("bp_count_pop", {27'd0, fifo_count}, 32'd15);
    tick();
    check("bp_count_after", {27'd0, fifo_count}, 32'd15);
    check("bp_state_after", {29'd0, state_dbg}, 32'd7);
    stop_line("bp");
    drain_check("bp");

    // Abort with stop in L_DATA, then the basic line again
    exp_addr_q.push_back(13'h1800);
    exp_addr_q.push_back(13'h0050);
    start_line(8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    check("abort_state_ldata", {29'd0, state_dbg}, 32'd4);
    stop_line("abort");
    repeat (3) tick();
    check("abort_idle_addr", {19'd0, vram_addr}, 32'h0050);
    check("abort_idle_state", {29'd0, state_dbg}, 32'd0);
    drain_check("abort");
    run_basic("rerun1");

    // Asynchronous reset after the first push, then the basic line again
    exp_addr_q.push_back(13'h1800);
    exp_addr_q.push_back(13'h0050);
    exp_addr_q.push_back(13'h0051);
    start_line(8'h00, 8'h00, 8'h00);
    repeat (9) tick();
    check("areset_count_before", {27'd0, fifo_count}, 32'd8);
    #3;
    reset = 1'b1;
    #1;
    check("areset_count", {27'd0, fifo_count}, 32'd0);
    check("areset_valid", {31'd0, pix_valid}, 32'd0);
    check("areset_state", {29'd0, state_dbg}, 32'd0);
    check("areset_addr", {19'd0, vram_addr}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    drain_check("areset");
    run_basic("rerun2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ppu_bg_fetcher.md
# ppu_bg_fetcher

Background tile fetcher and pixel FIFO for the PPU. It walks one scanline of the background tile map in VRAM and reads the tile number and, in CGB mode, the tile attribute. It then reads the two tile-data bitplanes and pushes decoded pixels into a 16-entry FIFO that the pixel mixer drains one pixel per dot. It reads both VRAM banks in parallel through the bank0/bank1 read ports and never writes VRAM.

## Interface
Parameters: none.
- clk  in  1  system clock; all state on posedge
- reset  in  1  asynchronous, active-high; returns block to IDLE, FIFO empty
- dot_en  in  1  dot-clock enable; state advances only when high
- cgb  in  1  CGB mode; when low, attributes forced to 8'h00
- start  in  1  pulse: begin a new scanline (sampled when dot_en)
- stop  in  1  abort: to IDLE, flush FIFO (sampled when dot_en, wins over start)
- bg_map_sel  in  1  LCDC.3: map at 0x1C00 if 1, else 0x1800
- tile_data_sel  in  1  LCDC.4: 1 = unsigned 0x0000 base, 0 = signed 0x1000 base
- scx, scy, ly  in  8 each  scroll and current line; latched on start
- vram_addr  out  13  VRAM read address; reset 13'h0000
- vram_rdata_bank0, vram_rdata_bank1  in  8 each  VRAM data, valid one dot_en cycle after vram_addr
- pix_valid  out  1  FIFO head valid and discard complete; reset 0
- pix_color  out  2  head pixel colour index; reset 0
- pix_pal  out  3  head CGB palette (attr[2:0]); reset 0
- pix_prio  out  1  head BG-over-OBJ priority (attr[7]); reset 0
- pix_pop  in  1  consume head pixel (honoured only when pix_valid && dot_en)
- fifo_count  out  5  entries held, 0..16; reset 0

## Operation
- On start: latch y = (ly + scy) mod 256, x_tile = scx[7:3], discard = scx[2:0]. Flush FIFO and enter T_ADDR.
- States: IDLE, T_ADDR, T_DATA, L_ADDR, L_DATA, H_ADDR, H_DATA, PUSH. Each transition takes one dot_en cycle, except PUSH, which waits.
- T_ADDR: vram_addr = {2'b11, bg_map_sel, y[7:3], x_tile}.
- T_DATA: tile = bank0; attr = cgb ? bank1 : 0. Attribute bits: [7] prio, [6] yflip, [5] xflip, [3] bank, [2:0] pal.
- L_ADDR and H_ADDR: row = attr[6] ? ~y[2:0] : y[2:0]. vram_addr = {tile_data_sel ? 1'b0 : ~tile[7], tile, row, hi}, where hi = 0 for L and 1 for H.
- L_DATA and H_DATA: capture lo or hi from attr[3] ? bank1 : bank0.
- PUSH: wait until fifo_count <= 8. Then append 8 pixels: colour {hi[b], lo[b]} for b = 7 down to 0, or 0 up to 7 when attr[5] xflip is set. Every pixel carries attr pal/prio. Then x_tile = x_tile + 1 (5-bit wrap 31->0) and go to T_ADDR.
- Discard: while discard != 0 and FIFO is non-empty, drop one head pixel per dot_en cycle and decrement. pix_valid stays 0 until discard reaches 0.
- Fetching continues until stop. IDLE holds vram_addr unchanged.
- Push and pop in the same cycle: count = count + 8 - 1. Overflow is impossible because push requires count <= 8.
- pix_pop while pix_valid = 0 is ignored. No underflow.
- start while busy restarts the line: flush, re-latch, T_ADDR.
- stop and start together: stop wins.
- Async reset mid-fetch: all state cleared immediately, with no partial push.

## Timing
- dot_en cycle n: start sampled. n+1: T_ADDR address on vram_addr.
- T_DATA at n+2, L_ADDR at n+3, L_DATA at n+4, H_ADDR at n+5, H_DATA at n+6, PUSH at n+7.
- First 8 pixels appear in the FIFO at n+8, so fifo_count = 8 at n+8.
- With scx[2:0] = 0, pix_valid = 1 from n+8. With discard d, pix_valid = 1 from n+8+d.
- Steady state: one tile per 7 dot_en cycles while the consumer pops at most 1 per cycle. FIFO never starves after the first push.
- dot_en low freezes all state, outputs and vram_addr.

## Test plan
- Fetch and push order:
  - Stimulus: reset, cgb = 0, scx = scy = ly = 0, bg_map_sel = 0, map[0x1800] = 0x05, tile_data_sel = 1, bank0[0x0050] = 0xF0, bank0[0x0051] = 0xCC, start.
  - Required: addresses 0x1800, 0x0050, 0x0051 issued. fifo_count = 8 at n+8. Popped colours 3,3,1,1,2,2,0,0.
- Signed addressing:
  - Stimulus: tile_data_sel = 0, tile 0x80, y = 3.
  - Required: lo address 0x0806, hi address 0x0807. With tile 0x00, addresses are 0x1006 and 0x1007.
- CGB attributes:
  - Stimulus: cgb = 1, bank1 map attr = 0xEB (prio, yflip, xflip, bank1, pal 3), y = 1.
  - Required: tile data read from bank1 at row 6. Pixels emitted LSB-first, with pix_pal = 3 and pix_prio = 1.
- Fine scroll and wrap:
  - Stimulus: scx = 0xFD.
  - Required: first map column 31, then column 0. First 5 pixels discarded; pix_valid rises at n+13.
- Backpressure:
  - Stimulus: no pops after the first tile.
  - Required: fifo_count goes 8, then 16, then the fetcher holds in PUSH. One pop brings count to 15. Count never exceeds 16.
- Abort:
  - Stimulus: assert stop in L_DATA. Separately, assert reset asynchronously mid-fetch.
  - Required: both cases go to IDLE with fifo_count = 0 and pix_valid = 0. The next start repeats the first scenario exactly.
